// File: rtl/rtlmem_rdarb_if.sv
// rtlmem_rdarb_if -- requester-side read bus of the memory read-port arbiter.
//   req   per-requester read request (master -> slave)
//   radd  packed read addresses, requester i at [i*G_RDADDR +: G_RDADDR]
//   gnt   one-hot grant, same cycle as the accepted request (slave -> master)
//   rvld  one-hot read-data valid, one cycle after gnt (slave -> master)
//   rdat  shared read data bus, aligned with rvld (slave -> master)
interface rtlmem_rdarb_if #(
  parameter int G_NREQ    = 4,
  parameter int G_RDADDR  = 10,
  parameter int G_RDWIDTH = 16
);
  logic [G_NREQ-1:0]          req;
  logic [G_NREQ*G_RDADDR-1:0] radd;
  logic [G_NREQ-1:0]          gnt;
  logic [G_NREQ-1:0]          rvld;
  logic [G_RDWIDTH-1:0]       rdat;

  modport master (output req, radd, input gnt, rvld, rdat);
  modport slave  (input req, radd, output gnt, rvld, rdat);
endinterface

// File: rtl/rtlmem_rdarb.sv
// rtlmem_rdarb -- read-port arbiter and clear sequencer for a simple-dual-port
// memory wrapper with 1-cycle read latency.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr_req               level clear request, honoured only in RUN
//   clr_busy              clear in progress, reads blocked
//   mem_clren/mem_clrrdy  memory content-clear handshake
//   rd (slave)            requester bus: req/radd in, gnt/rvld/rdat out
//   memre/memra/memdo     memory read port
//
// Build option: RTL_MEM_RDARB_FIXPRIO_EN selects fixed priority (lowest index
// wins, no round-robin pointer); undefined gives round-robin arbitration.
module rtlmem_rdarb #(
  parameter int G_NREQ       = 4,
  parameter int G_RDADDR     = 10,
  parameter int G_RDWIDTH    = 16,
  parameter int G_CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 mem_clren,
  input  logic                 mem_clrrdy,
  rtlmem_rdarb_if.slave        rd,
  output logic                 memre,
  output logic [G_RDADDR-1:0]  memra,
  input  logic [G_RDWIDTH-1:0] memdo
);

  typedef enum logic [1:0] {CLR_START, CLR_WAIT, RUN} state_t;

  localparam state_t RST_STATE = (G_CLR_ON_RST != 0) ? CLR_START : RUN;

  state_t              state_q, state_d;
  logic                wait_seen_q, wait_seen_d;
  logic [G_NREQ-1:0]   gnt;
  logic [G_NREQ-1:0]   rvld_q;
  logic                grant_en;
  logic                found;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      wait_seen_q <= 1'b0;
      rvld_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_seen_q <= wait_seen_d;
      rvld_q      <= gnt;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_seen_d = 1'b0;
    case (state_q)
      CLR_START: state_d = CLR_WAIT;
      CLR_WAIT: begin
        // mem_clrrdy may still show the pre-clear idle level on the first
        // wait cycle, so it is only trusted from the second cycle on.
        wait_seen_d = 1'b1;
        if (wait_seen_q && mem_clrrdy) state_d = RUN;
      end
      RUN:     if (clr_req) state_d = CLR_START;
      default: state_d = RST_STATE;
    endcase
  end

  assign clr_busy = (state_q != RUN);
  // Gated by rst_n so the pulse drops the moment reset asserts, even though
  // the reset state itself is CLR_START.
  assign mem_clren = (state_q == CLR_START) && rst_n;

  // --------------------------------------------------------- arbitration
  assign grant_en = (state_q == RUN) && !clr_req;

`ifdef RTL_MEM_RDARB_FIXPRIO_EN
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < G_NREQ; i++) begin
      if (grant_en && !found && rd.req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  localparam int PTR_W = $clog2(G_NREQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] idx_w;
  int unsigned      idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Search upward from the pointer, wrapping at G_NREQ-1; the pointer then
  // moves just past the winner.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned off = 0; off < G_NREQ; off++) begin
      idx = 32'(rr_ptr_q) + off;
      if (idx >= unsigned'(G_NREQ)) idx = idx - unsigned'(G_NREQ);
      idx_w = PTR_W'(idx);
      if (grant_en && !found && rd.req[idx_w]) begin
        gnt[idx_w] = 1'b1;
        found      = 1'b1;
        rr_ptr_d   = (idx + 1 == unsigned'(G_NREQ)) ? '0 : PTR_W'(idx + 1);
      end
    end
  end
`endif

  // ------------------------------------------------------ memory port
  always_comb begin
    memra = '0;
    for (int unsigned i = 0; i < G_NREQ; i++) begin
      if (gnt[i]) memra = rd.radd[i*G_RDADDR +: G_RDADDR];
    end
  end

  assign memre   = |gnt;
  assign rd.gnt  = gnt;
  assign rd.rvld = rvld_q;
  assign rd.rdat = memdo;

endmodule
